// File: rtl/stepper_spi_pkg.sv
// Shared constants, opcodes and state encoding for the SPI stepper command decoder.
package stepper_spi_pkg;

    localparam int unsigned DW    = 21;
    localparam int unsigned NDATA = 3;
    localparam int unsigned BW    = 8;
    localparam int unsigned CW    = 7;
    localparam int unsigned CNT_W = 2;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_WR_PERIOD = 3'd1;
    localparam logic [2:0] OP_WR_STEPS  = 3'd2;
    localparam logic [2:0] OP_WR_CTRL   = 3'd3;
    localparam logic [2:0] OP_RD_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_READ = 2'd2
    } state_e;

    // Readback byte shown to the host whenever no RD_LEFT reply is in flight.
    function automatic logic [BW-1:0] status_byte(input logic err, input logic busy,
                                                  input logic nz, input logic dir,
                                                  input logic en);
        return {1'b1, 2'b00, err, busy, nz, dir, en};
    endfunction

endpackage

// File: rtl/spi_stepper_cmd_if.sv
// Byte-level link between the SPI slave engine and the command decoder.
interface spi_stepper_cmd_if;
    import stepper_spi_pkg::*;

    logic          spi_cs;
    logic          spi_done;
    logic [BW-1:0] spi_dout;
    logic [BW-1:0] spi_din;

    modport master (output spi_cs, output spi_done, output spi_dout, input spi_din);
    modport slave  (input spi_cs, input spi_done, input spi_dout, output spi_din);
endinterface

// File: rtl/spi_byte_strobe.sv
// One-cycle strobe per completed transfer; done rises seen while cs is high are aborts.
module spi_byte_strobe
    import stepper_spi_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          spi_cs,
    input  logic          spi_done,
    input  logic [BW-1:0] spi_dout,
    output logic          byte_v,
    output logic [BW-1:0] byte_data
);

    logic          prev_done_q, prev_done_d;
    logic          byte_v_q, byte_v_d;
    logic [BW-1:0] byte_q, byte_d;

    always_comb begin
        prev_done_d = spi_done;
        byte_v_d    = spi_done & ~prev_done_q & ~spi_cs;
        byte_d      = byte_v_d ? spi_dout : byte_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_done_q <= 1'b0;
            byte_v_q    <= 1'b0;
            byte_q      <= '0;
        end else begin
            prev_done_q <= prev_done_d;
            byte_v_q    <= byte_v_d;
            byte_q      <= byte_d;
        end
    end

    assign byte_v    = byte_v_q;
    assign byte_data = byte_q;

endmodule

// File: rtl/spi_stepper_cmd.sv
// Decodes MIDI-style SPI frames into stepper control registers and serves readback bytes.
module spi_stepper_cmd
    import stepper_spi_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    spi_stepper_cmd_if.slave    spi,
    input  logic [DW-1:0]       steps_left,
    output logic [DW-1:0]       period,
    output logic [DW-1:0]       steps,
    output logic                dir,
    output logic                enable,
    output logic                load,
    output logic                err
);

    logic          byte_v;
    logic [BW-1:0] byte_data;

    spi_byte_strobe u_strobe (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi.spi_cs),
        .spi_done  (spi.spi_done),
        .spi_dout  (spi.spi_dout),
        .byte_v    (byte_v),
        .byte_data (byte_data)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    rd_sh_q, rd_sh_d;
    logic [DW-1:0]    period_q, period_d;
    logic [DW-1:0]    steps_q, steps_d;
    logic             dir_q, dir_d;
    logic             enable_q, enable_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic [BW-1:0]    spi_din_q, spi_din_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rd_sh_d  = rd_sh_q;
        period_d = period_q;
        steps_d  = steps_q;
        dir_d    = dir_q;
        enable_d = enable_q;
        load_d   = 1'b0;
        err_d    = err_q;

        if (byte_v) begin
            if (byte_data[7]) begin
                op_d    = byte_data[6:4];
                acc_d   = '0;
                state_d = ST_IDLE;
                case (byte_data[6:4])
                    OP_NOP:       err_d = 1'b0;
                    OP_WR_PERIOD,
                    OP_WR_STEPS: begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_W'(NDATA);
                    end
                    OP_WR_CTRL: begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_W'(1);
                    end
                    OP_RD_LEFT: begin
                        state_d = ST_READ;
                        cnt_d   = CNT_W'(NDATA);
                        rd_sh_d = steps_left;
                    end
                    default:      err_d = 1'b1;
                endcase
                // An interrupted frame outranks a NOP's error clear.
                if (state_q != ST_IDLE) err_d = 1'b1;
            end else begin
                case (state_q)
                    ST_DATA: begin
                        acc_d = {acc_q[DW-8:0], byte_data[CW-1:0]};
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                            case (op_q)
                                OP_WR_PERIOD: period_d = acc_d;
                                OP_WR_STEPS: begin
                                    steps_d = acc_d;
                                    load_d  = 1'b1;
                                end
                                OP_WR_CTRL: begin
                                    enable_d = byte_data[0];
                                    dir_d    = byte_data[1];
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_READ: begin
                        rd_sh_d = {rd_sh_q[DW-8:0], CW'(0)};
                        cnt_d   = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end

        // Readback byte is built from next-state values so it settles one clk after byte_v.
        if (state_d == ST_READ) begin
            spi_din_d = {1'b0, rd_sh_d[DW-1 -: CW]};
        end else begin
            spi_din_d = status_byte(err_d, state_d != ST_IDLE, |steps_left, dir_d, enable_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_NOP;
            acc_q     <= '0;
            rd_sh_q   <= '0;
            period_q  <= '0;
            steps_q   <= '0;
            dir_q     <= 1'b0;
            enable_q  <= 1'b0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            spi_din_q <= status_byte(1'b0, 1'b0, |steps_left, 1'b0, 1'b0);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            rd_sh_q   <= rd_sh_d;
            period_q  <= period_d;
            steps_q   <= steps_d;
            dir_q     <= dir_d;
            enable_q  <= enable_d;
            load_q    <= load_d;
            err_q     <= err_d;
            spi_din_q <= spi_din_d;
        end
    end

    assign spi.spi_din = spi_din_q;
    assign period      = period_q;
    assign steps       = steps_q;
    assign dir         = dir_q;
    assign enable      = enable_q;
    assign load        = load_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spi_stepper_cmd.sv
// Directed bench for spi_stepper_cmd: models the SPI slave byte handshake as seen by the decoder.
module tb_spi_stepper_cmd;
    import stepper_spi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_stepper_cmd_if bus ();

    logic [DW-1:0] steps_left;
    logic [DW-1:0] period;
    logic [DW-1:0] steps;
    logic          dir;
    logic          enable;
    logic          load;
    logic          err;

    spi_stepper_cmd u_dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (bus.slave),
        .steps_left (steps_left),
        .period     (period),
        .steps      (steps),
        .dir        (dir),
        .enable     (enable),
        .load       (load),
        .err        (err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int load_cnt = 0;

    always @(posedge clk) if (load === 1'b1) load_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transfer; din is what the slave would load at this cs fall.
    task automatic xfer(input logic [7:0] b, output logic [7:0] din);
        din = bus.spi_din;
        bus.spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        bus.spi_dout = b;
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_cs   = 1'b1;
        bus.spi_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] unused_din;
        xfer(b, unused_din);
    endtask

    logic [7:0] rd;

    initial begin
        reset        = 1'b1;
        bus.spi_cs   = 1'b1;
        bus.spi_done = 1'b0;
        bus.spi_dout = 8'h00;
        steps_left   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_period", 32'(period), 32'h0);
        chk("rst_steps",  32'(steps),  32'h0);
        chk("rst_ctrl",   {30'd0, dir, enable}, 32'h0);
        chk("rst_err",    32'(err),    32'h0);
        chk("rst_load",   32'(load),   32'h0);
        chk("rst_din",    32'(bus.spi_din), 32'h80);

        load_cnt = 0;
        send(8'h90); send(8'h01); send(8'h00); send(8'h05);
        chk("wr_period",      32'(period), 32'h4005);
        chk("wr_period_load", 32'(load_cnt), 32'd0);
        chk("wr_period_err",  32'(err), 32'h0);

        load_cnt = 0;
        send(8'hA0); send(8'h7F); send(8'h7F); send(8'h7F);
        chk("wr_steps",      32'(steps), 32'h1FFFFF);
        chk("wr_steps_load", 32'(load_cnt), 32'd1);
        chk("wr_steps_keep", 32'(period), 32'h4005);

        send(8'hB0); send(8'h03);
        chk("wr_ctrl",     {30'd0, dir, enable}, 32'h3);
        chk("wr_ctrl_din", 32'(bus.spi_din), 32'h83);

        steps_left = 21'h0ABCDE;
        repeat (2) @(negedge clk);
        send(8'hC0);
        xfer(8'h00, rd); chk("rd_byte0", 32'(rd), 32'h2A);
        xfer(8'h00, rd); chk("rd_byte1", 32'(rd), 32'h79);
        xfer(8'h00, rd); chk("rd_byte2", 32'(rd), 32'h5E);
        chk("rd_status", 32'(bus.spi_din), 32'h87);
        chk("rd_err",    32'(err), 32'h0);
        steps_left = '0;
        repeat (2) @(negedge clk);

        send(8'h90); send(8'h01);
        send(8'hB0); send(8'h01);
        chk("partial_err",    32'(err), 32'h1);
        chk("partial_period", 32'(period), 32'h4005);
        chk("partial_ctrl",   {30'd0, dir, enable}, 32'h1);
        chk("partial_din",    32'(bus.spi_din), 32'h91);
        send(8'h80);
        chk("nop_clear", 32'(err), 32'h0);

        send(8'h05);
        chk("idle_data_err", 32'(err), 32'h1);
        send(8'h80);
        send(8'hD0);
        chk("bad_op_err", 32'(err), 32'h1);
        chk("bad_op_din", 32'(bus.spi_din), 32'h91);
        send(8'h80);

        // Aborted transfer: cs rises before done.
        bus.spi_cs = 1'b0;
        repeat (2) @(negedge clk);
        bus.spi_cs = 1'b1;
        @(negedge clk);
        bus.spi_dout = 8'h90;
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_din", 32'(bus.spi_din), 32'h81);
        chk("abort_err", 32'(err), 32'h0);
        send(8'h01);
        chk("abort_idle",   32'(err), 32'h1);
        chk("abort_period", 32'(period), 32'h4005);
        send(8'h80);

        send(8'h90); send(8'h01);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_period", 32'(period), 32'h0);
        chk("midrst_steps",  32'(steps), 32'h0);
        chk("midrst_ctrl",   {30'd0, dir, enable}, 32'h0);
        chk("midrst_din",    32'(bus.spi_din), 32'h80);
        send(8'h05);
        chk("midrst_fresh", 32'(err), 32'h1);
        chk("midrst_keep",  32'(period), 32'h0);
        send(8'hB0); send(8'h02);
        chk("midrst_ctrl2", {30'd0, dir, enable}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
